d_mem_arbiter: RTL and testbench
================================

# d_mem_arbiter

Two-port arbiter that shares the single-ported `d_mem_spram` data memory between the core load/store unit (port 0) and a secondary master such as DMA or debug (port 1). Port 0 has fixed priority. A saturating starvation counter guarantees port 1 progress, and a lock input keeps the grant on one port across back-to-back accesses (read-modify-write). The block sits between the requesters and the memory, forwards the selected request combinationally, and routes the one-cycle-latency read data back to the port that issued the read.

## Interface
- `AddrWidth`, default `DMemAddrWidth` (config_pkg): byte address width.
- `StarveLimit`, default 4: consecutive denied cycles of port 1 after which port 1 is forced a grant; range 1..15.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low (asserted when 0).
- `pN_req`  in  1  port N (N = 0, 1) request; held with payload stable until `pN_gnt`.
- `pN_lock`  in  1  port N requests to keep ownership for its next cycle.
- `pN_we`  in  1  write (1) / read (0).
- `pN_width`  in  mem_width_t  BYTE/HALFWORD/WORD.
- `pN_sign_extend`  in  1  load sign extension.
- `pN_addr`  in  AddrWidth  byte address.
- `pN_wdata`  in  32  store data, LSB-aligned.
- `pN_gnt`  out  1  request accepted this cycle (combinational).
- `pN_rvalid`  out  1  read data valid; asserted one cycle after a granted read.
- `pN_rdata`  out  32  read data; 0 when `pN_rvalid` = 0.
- `mem_addr`  out  AddrWidth  to memory `addr`.
- `mem_width`  out  mem_width_t  to memory `width`.
- `mem_sign_extend`  out  1  to memory `sign_extend`.
- `mem_data_in`  out  32  to memory `data_in`.
- `mem_write_enable`  out  1  to memory `write_enable`.
- `mem_data_out`  in  32  from memory `data_out`, valid the cycle after the address.

## Operation
- Registers: `owner_q` (0/1), `locked_q`, `starve_q` (4 bits), `rsp_valid_q`, `rsp_port_q`.
- Grant decision per cycle, first match wins:
  1. `locked_q` set and the owner still asserts req: grant the owner.
  2. `p1_req` and `starve_q == StarveLimit`: grant port 1.
  3. `p0_req`: grant port 0.
  4. `p1_req`: grant port 1.
  5. Otherwise no grant.
- At most one `gnt` is high per cycle.
- Mux: the granted port's addr/width/sign_extend/wdata drive `mem_*`, and `mem_write_enable` = granted `we`. With no grant: `mem_write_enable` = 0, `mem_addr` = 0, `mem_width` = WORD, `mem_sign_extend` = 0, `mem_data_in` = 0.
- Lock:
  - `locked_q` <= grant & granted port's lock; `owner_q` <= granted port on any grant.
  - Lock overrides starvation. Lock releases when the owner drops lock or req.
  - Lock is ignored on a port that is not granted.
- Starvation counter:
  - `starve_q` <= 0 if `p1_gnt` or !`p1_req`.
  - Otherwise `starve_q` <= min(`starve_q`+1, StarveLimit); saturates, no wrap.
- Response:
  - `rsp_valid_q` <= grant & !we; `rsp_port_q` <= granted port.
  - `pN_rvalid` = `rsp_valid_q` & (`rsp_port_q` == N); `pN_rdata` = `mem_data_out` when valid.
  - Writes complete at grant and produce no rvalid.
- Misalignment and bank steering are handled by memory; the arbiter passes `addr`/`width` unchanged.
- Reset (`reset` = 0, sampled at posedge):
  - All registers clear to 0.
  - While `reset` = 0, both `gnt` outputs and `mem_write_enable` are forced to 0.
  - `rvalid` is 0 in the cycle after reset is sampled. A read granted the cycle before reset is dropped.

## Timing
- Request-to-grant: 0 cycles (combinational). Memory samples at the same posedge.
- Read: grant in cycle T, `pN_rvalid`/`pN_rdata` in cycle T+1.
- A new grant in T+1 is allowed (fully pipelined): one access per cycle sustained.
- Starvation bound: port 1 waits at most StarveLimit cycles after first assertion, unless port 0 holds lock.
- Simultaneous req with `starve_q` < StarveLimit and no lock: port 0 wins.
- Port switch needs no bubble cycle.

## Test plan
- Reset: drive `reset` = 0 for 2 cycles with both req high. Required: `gnt` = 0, `mem_write_enable` = 0, rvalid = 0. In the first cycle after release, `p0_gnt` = 1.
- Read latency: memory preloaded 0xDEADBEEF at address 0x10. Port 0 reads WORD at 0x10 in cycle T. Required: `p0_rvalid` = 1 with `p0_rdata` = 0xDEADBEEF at T+1, and `p1_rvalid` = 0.
- Starvation: StarveLimit = 4, both ports request continuously. Required: `p0_gnt` for 4 cycles, then `p1_gnt` in the 5th, `starve_q` back to 0, and the pattern repeats.
- Lock: port 1 granted with lock = 1 while `p0_req` = 1. Required: port 1 keeps the grant for 3 locked cycles even with `starve_q` irrelevant. Lock drop gives `p0_gnt` the next cycle.
- Back-to-back mixed traffic: port 0 writes BYTE 0xA5 at 0x21 in T, port 1 reads BYTE unsigned at 0x21 in T+1. Required: `mem_write_enable` = 1 only in T, `p1_rvalid` at T+2 with `p1_rdata` = 0x000000A5.
- Reset mid-read: read granted in T, `reset` = 0 sampled at end of T. Required: no rvalid in T+1, and all counters are 0.

Source files
------------

// File: rtl/config_pkg.sv
// config_pkg: shared data-memory configuration (address width, access width encoding)
package config_pkg;
  localparam int DMemAddrWidth = 12;
  typedef enum logic [1:0] {BYTE = 2'd0, HALFWORD = 2'd1, WORD = 2'd2} mem_width_t;
endpackage

// File: rtl/d_mem_arbiter_if.sv
// d_mem_arbiter_if: one requester port of the data-memory arbiter
// master drives req/lock/we/width/sign_extend/addr/wdata; slave returns gnt/rvalid/rdata.
interface d_mem_arbiter_if import config_pkg::*; #(parameter int AddrWidth = DMemAddrWidth);
  logic req;
  logic lock;
  logic we;
  mem_width_t width;
  logic sign_extend;
  logic [AddrWidth-1:0] addr;
  logic [31:0] wdata;
  logic gnt;
  logic rvalid;
  logic [31:0] rdata;
  modport master (output req, lock, we, width, sign_extend, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, lock, we, width, sign_extend, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: shares d_mem_spram between the load/store unit (p0) and a secondary master (p1)
// Ports: clk, reset (sync, active-low); p0/p1 requester interfaces (slave side);
// mem_addr/mem_width/mem_sign_extend/mem_data_in/mem_write_enable to memory, mem_data_out back.
module d_mem_arbiter import config_pkg::*; #(
  parameter int AddrWidth = DMemAddrWidth,
  parameter int StarveLimit = 4
) (
  input logic clk,
  input logic reset,
  d_mem_arbiter_if.slave p0,
  d_mem_arbiter_if.slave p1,
  output logic [AddrWidth-1:0] mem_addr,
  output mem_width_t mem_width,
  output logic mem_sign_extend,
  output logic [31:0] mem_data_in,
  output logic mem_write_enable,
  input logic [31:0] mem_data_out
);
  localparam logic [3:0] Limit = 4'(StarveLimit);
  logic owner_q, locked_q, rsp_valid_q, rsp_port_q;
  logic [3:0] starve_q;
  logic lock_hit, starve_hit, gnt_any, sel, g_we, g_lock;
  // sel names the winning port; it only matters when gnt_any is set
  always_comb begin
    lock_hit = locked_q & (owner_q ? p1.req : p0.req);
    starve_hit = p1.req & (starve_q == Limit);
    gnt_any = reset & (p0.req | p1.req);
    sel = lock_hit ? owner_q : (starve_hit | ~p0.req);
    g_we = sel ? p1.we : p0.we;
    g_lock = sel ? p1.lock : p0.lock;
  end
  assign p0.gnt = gnt_any & ~sel;
  assign p1.gnt = gnt_any & sel;
  assign mem_write_enable = gnt_any & g_we;
  assign mem_addr = gnt_any ? (sel ? p1.addr : p0.addr) : '0;
  assign mem_width = gnt_any ? (sel ? p1.width : p0.width) : WORD;
  assign mem_sign_extend = gnt_any & (sel ? p1.sign_extend : p0.sign_extend);
  assign mem_data_in = gnt_any ? (sel ? p1.wdata : p0.wdata) : '0;
  assign p0.rvalid = rsp_valid_q & ~rsp_port_q;
  assign p1.rvalid = rsp_valid_q & rsp_port_q;
  assign p0.rdata = p0.rvalid ? mem_data_out : '0;
  assign p1.rdata = p1.rvalid ? mem_data_out : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q <= 1'b0;
      locked_q <= 1'b0;
      starve_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_port_q <= 1'b0;
    end else begin
      locked_q <= gnt_any & g_lock;
      if (gnt_any) owner_q <= sel;
      // saturates at the limit so a denied port 1 keeps its forced grant pending
      starve_q <= (p1.gnt | ~p1.req) ? '0 : (starve_q == Limit ? starve_q : starve_q + 4'd1);
      rsp_valid_q <= gnt_any & ~g_we;
      rsp_port_q <= sel;
    end
  end
endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb_d_mem_arbiter: directed scenarios plus randomized traffic against a reference model
module tb_d_mem_arbiter import config_pkg::*;;
  localparam int AW = 12;
  localparam int LIMIT = 4;
  logic clk, reset;
  logic [AW-1:0] mem_addr;
  mem_width_t mem_width;
  logic mem_sign_extend, mem_write_enable;
  logic [31:0] mem_data_in, mem_data_out;
  int checks = 0, failures = 0;
  d_mem_arbiter_if #(.AddrWidth(AW)) p0 ();
  d_mem_arbiter_if #(.AddrWidth(AW)) p1 ();
  d_mem_arbiter #(.AddrWidth(AW), .StarveLimit(LIMIT)) dut (
    .clk(clk), .reset(reset), .p0(p0), .p1(p1),
    .mem_addr(mem_addr), .mem_width(mem_width), .mem_sign_extend(mem_sign_extend),
    .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] mem [0:(1<<AW)-1];
  bit mem_init = 1'b0;
  function automatic logic [31:0] rd(input logic [AW-1:0] a, input mem_width_t w, input logic se);
    logic [31:0] v;
    v = {mem[a + AW'(3)], mem[a + AW'(2)], mem[a + AW'(1)], mem[a]};
    return w == BYTE ? {{24{se & v[7]}}, v[7:0]} : w == HALFWORD ? {{16{se & v[15]}}, v[15:0]} : v;
  endfunction
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 8'($urandom);
      mem[16] <= 8'hEF;
      mem[17] <= 8'hBE;
      mem[18] <= 8'hAD;
      mem[19] <= 8'hDE;
      mem_init <= 1'b1;
    end else if (mem_write_enable) begin
      mem[mem_addr] <= mem_data_in[7:0];
      if (mem_width != BYTE) mem[mem_addr + AW'(1)] <= mem_data_in[15:8];
      if (mem_width == WORD) begin
        mem[mem_addr + AW'(2)] <= mem_data_in[23:16];
        mem[mem_addr + AW'(3)] <= mem_data_in[31:24];
      end
    end
    mem_data_out <= rd(mem_addr, mem_width, mem_sign_extend);
  end
  int m_owner = 0, m_starve = 0, m_rport = 0;
  bit m_locked = 0, m_rv = 0;
  logic [31:0] m_rdata = '0;
  function automatic int ref_grant();
    if (reset !== 1'b1) return -1;
    if (m_locked && (m_owner == 1 ? p1.req : p0.req)) return m_owner;
    if (p1.req && m_starve == LIMIT) return 1;
    if (p0.req) return 0;
    if (p1.req) return 1;
    return -1;
  endfunction
  task automatic model_step();
    int g;
    g = ref_grant();
    if (reset !== 1'b1) begin
      m_owner = 0; m_starve = 0; m_rport = 0; m_locked = 0; m_rv = 0;
    end else begin
      m_rv = g >= 0 && !(g == 1 ? p1.we : p0.we);
      m_rport = g;
      if (m_rv) m_rdata = g == 1 ? rd(p1.addr, p1.width, p1.sign_extend) : rd(p0.addr, p0.width, p0.sign_extend);
      m_locked = g >= 0 && (g == 1 ? p1.lock : p0.lock);
      if (g >= 0) m_owner = g;
      m_starve = (g == 1 || !p1.req) ? 0 : (m_starve + 1 > LIMIT ? LIMIT : m_starve + 1);
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int port, input logic req, lock, we, input mem_width_t w,
                       input logic se, input logic [AW-1:0] a, input logic [31:0] d);
    if (port == 0) begin
      p0.req = req; p0.lock = lock; p0.we = we; p0.width = w; p0.sign_extend = se; p0.addr = a; p0.wdata = d;
    end else begin
      p1.req = req; p1.lock = lock; p1.we = we; p1.width = w; p1.sign_extend = se; p1.addr = a; p1.wdata = d;
    end
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, WORD, 0, '0, '0);
    drive(1, 0, 0, 0, WORD, 0, '0, '0);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1, 1, 1, WORD, 0, 12'h300, 32'h1234_5678);
    drive(1, 1, 0, 0, WORD, 0, 12'h304, '0);
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if ({p0.gnt, p1.gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b expected 00", {p0.gnt, p1.gnt}); end
      checks++;
      if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", mem_write_enable); end
      tick();
      checks++;
      if ({p0.rvalid, p1.rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid: got %b expected 00", {p0.rvalid, p1.rvalid}); end
    end
    checks++;
    if ({dut.starve_q, dut.locked_q} !== 5'd0) begin failures++; $display("FAIL reset_regs: got %b expected 0", {dut.starve_q, dut.locked_q}); end
    reset = 1'b1;
    #4;
    checks++;
    if ({p0.gnt, p1.gnt} !== 2'b10) begin failures++; $display("FAIL reset_release_gnt: got %b expected 10", {p0.gnt, p1.gnt}); end
    tick();
    idle();
    tick();
  endtask
  task automatic test_read_latency();
    drive(0, 1, 0, 0, WORD, 0, 12'h010, '0);
    #4;
    checks++;
    if (p0.gnt !== 1'b1) begin failures++; $display("FAIL read_gnt: got %b expected 1", p0.gnt); end
    tick();
    idle();
    #4;
    checks++;
    if (p0.rvalid !== 1'b1 || p0.rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL read_data: got rvalid=%b rdata=%h expected 1 deadbeef", p0.rvalid, p0.rdata);
    end
    checks++;
    if (p1.rvalid !== 1'b0 || p1.rdata !== 32'h0) begin failures++; $display("FAIL read_p1_quiet: got %b %h expected 0 0", p1.rvalid, p1.rdata); end
    tick();
  endtask
  task automatic test_starvation();
    drive(0, 1, 0, 0, WORD, 0, 12'h010, '0);
    drive(1, 1, 0, 0, WORD, 0, 12'h020, '0);
    for (int c = 0; c < 10; c++) begin
      #4;
      checks++;
      if ({p0.gnt, p1.gnt} !== ((c % 5 == 4) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL starve_gnt c=%0d: got %b expected %b", c, {p0.gnt, p1.gnt}, (c % 5 == 4) ? 2'b01 : 2'b10);
      end
      checks++;
      if (dut.starve_q !== 4'(c % 5)) begin failures++; $display("FAIL starve_cnt c=%0d: got %0d expected %0d", c, dut.starve_q, c % 5); end
      tick();
    end
    idle();
    tick();
  endtask
  task automatic test_lock();
    drive(0, 1, 0, 0, WORD, 0, 12'h010, '0);
    drive(1, 1, 1, 0, WORD, 0, 12'h020, '0);
    for (int c = 0; c < 10; c++) begin
      if (c == 8) p1.lock = 1'b0;
      #4;
      checks++;
      if ({p0.gnt, p1.gnt} !== ((c >= 4 && c <= 8) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL lock_gnt c=%0d: got %b expected %b", c, {p0.gnt, p1.gnt}, (c >= 4 && c <= 8) ? 2'b01 : 2'b10);
      end
      tick();
    end
    idle();
    tick();
  endtask
  task automatic test_back_to_back();
    drive(0, 1, 0, 1, BYTE, 0, 12'h021, 32'h0000_00A5);
    #4;
    checks++;
    if (p0.gnt !== 1'b1 || mem_write_enable !== 1'b1 || mem_addr !== 12'h021) begin
      failures++; $display("FAIL b2b_write: got gnt=%b we=%b addr=%h expected 1 1 021", p0.gnt, mem_write_enable, mem_addr);
    end
    tick();
    drive(0, 0, 0, 0, WORD, 0, '0, '0);
    drive(1, 1, 0, 0, BYTE, 0, 12'h021, '0);
    #4;
    checks++;
    if (p1.gnt !== 1'b1 || mem_write_enable !== 1'b0) begin
      failures++; $display("FAIL b2b_read_gnt: got gnt=%b we=%b expected 1 0", p1.gnt, mem_write_enable);
    end
    tick();
    drive(1, 1, 0, 0, BYTE, 1, 12'h021, '0);
    #4;
    checks++;
    if (p1.rvalid !== 1'b1 || p1.rdata !== 32'h0000_00A5 || p0.rvalid !== 1'b0) begin
      failures++; $display("FAIL b2b_rdata_u: got rvalid=%b rdata=%h expected 1 000000a5", p1.rvalid, p1.rdata);
    end
    checks++;
    if (p1.gnt !== 1'b1) begin failures++; $display("FAIL b2b_pipelined_gnt: got %b expected 1", p1.gnt); end
    tick();
    idle();
    #4;
    checks++;
    if (p1.rvalid !== 1'b1 || p1.rdata !== 32'hFFFF_FFA5) begin
      failures++; $display("FAIL b2b_rdata_s: got rvalid=%b rdata=%h expected 1 ffffffa5", p1.rvalid, p1.rdata);
    end
    tick();
  endtask
  task automatic test_reset_mid_read();
    drive(0, 1, 1, 0, WORD, 0, 12'h010, '0);
    drive(1, 1, 0, 0, WORD, 0, 12'h020, '0);
    tick();
    tick();
    #4;
    checks++;
    if (p0.gnt !== 1'b1 || dut.starve_q !== 4'd2 || dut.locked_q !== 1'b1) begin
      failures++; $display("FAIL midrst_pre: got gnt=%b starve=%0d lock=%b expected 1 2 1", p0.gnt, dut.starve_q, dut.locked_q);
    end
    #1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle();
    #4;
    checks++;
    if (p0.rvalid !== 1'b0 || p0.rdata !== 32'h0 || p1.rvalid !== 1'b0) begin
      failures++; $display("FAIL midrst_rvalid: got %b %h %b expected 0 0 0", p0.rvalid, p0.rdata, p1.rvalid);
    end
    checks++;
    if ({dut.starve_q, dut.locked_q, dut.rsp_valid_q, dut.owner_q} !== 7'd0) begin
      failures++; $display("FAIL midrst_regs: got %b expected 0", {dut.starve_q, dut.locked_q, dut.rsp_valid_q, dut.owner_q});
    end
    tick();
  endtask
  task automatic test_random();
    bit pend0 = 0, pend1 = 0, g0, g1;
    int g;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom % 64) != 0;
      if (!pend0) begin
        pend0 = ($urandom % 3) != 0;
        drive(0, pend0, 0, 1'($urandom), mem_width_t'($urandom % 3), 1'($urandom), AW'($urandom % 64), $urandom);
      end
      if (!pend1) begin
        pend1 = ($urandom % 3) != 0;
        drive(1, pend1, 0, 1'($urandom), mem_width_t'($urandom % 3), 1'($urandom), AW'($urandom % 64), $urandom);
      end
      p0.lock = ($urandom % 3) == 0;
      p1.lock = ($urandom % 3) == 0;
      #4;
      g = ref_grant();
      checks++;
      if ({p0.gnt, p1.gnt} !== {g == 0, g == 1}) begin
        failures++; $display("FAIL rand_gnt c=%0d: got %b expected %b", c, {p0.gnt, p1.gnt}, {g == 0, g == 1});
      end
      checks++;
      if (mem_write_enable !== (g >= 0 && (g == 1 ? p1.we : p0.we))) begin
        failures++; $display("FAIL rand_we c=%0d: got %b", c, mem_write_enable);
      end
      checks++;
      if (mem_addr !== (g < 0 ? '0 : (g == 1 ? p1.addr : p0.addr)) || mem_data_in !== (g < 0 ? '0 : (g == 1 ? p1.wdata : p0.wdata))) begin
        failures++; $display("FAIL rand_mux c=%0d: got addr=%h data=%h", c, mem_addr, mem_data_in);
      end
      checks++;
      if ({p0.rvalid, p1.rvalid} !== {m_rv && m_rport == 0, m_rv && m_rport == 1}) begin
        failures++; $display("FAIL rand_rvalid c=%0d: got %b expected %b", c, {p0.rvalid, p1.rvalid}, {m_rv && m_rport == 0, m_rv && m_rport == 1});
      end
      checks++;
      if (p0.rdata !== ((m_rv && m_rport == 0) ? m_rdata : '0) || p1.rdata !== ((m_rv && m_rport == 1) ? m_rdata : '0)) begin
        failures++; $display("FAIL rand_rdata c=%0d: got %h %h expected %h", c, p0.rdata, p1.rdata, m_rdata);
      end
      g0 = p0.gnt;
      g1 = p1.gnt;
      tick();
      if (g0) pend0 = 0;
      if (g1) pend1 = 0;
    end
    reset = 1'b1;
    idle();
    tick();
  endtask
  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_read_latency();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
